fetch_unit: RTL

//  Instruction-fetch stage. Owns the PC, issues word fetches to the instruction

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Bus width, reset PC, canonical NOP word and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int DATA_WID = 32;

    localparam logic [DATA_WID-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [DATA_WID-1:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [DATA_WID-1:0] PC_STEP      = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    function automatic logic [DATA_WID-1:0] align_word(input logic [DATA_WID-1:0] addr);
        return {addr[DATA_WID-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and
// feeds IF/ID, holding a fetched word across back-end stalls and absorbing redirects.
//
//   state | meaning
//   BOOT  | first cycle out of reset, no request yet
//   REQ   | request outstanding at pc; an ack delivers or is discarded on redirect
//   HOLD  | fetched word parked while the back end is stalled
//   DROP  | redirect arrived with a request in flight; wait out its ack, then jump to tgt
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [DATA_WID-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [DATA_WID-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dcache_stall,
    input  logic                redirect,
    input  logic [DATA_WID-1:0] redirect_pc,
    output logic                imem_req,
    output logic [DATA_WID-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [DATA_WID-1:0] imem_rdata,
    output logic [DATA_WID-1:0] inst_out,
    output logic [DATA_WID-1:0] pc_out,
    output logic                icache_stall
);

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [DATA_WID-1:0] pc;
    logic [DATA_WID-1:0] pc_next;
    logic [DATA_WID-1:0] tgt;
    logic [DATA_WID-1:0] tgt_next;
    logic [DATA_WID-1:0] hold_inst;
    logic [DATA_WID-1:0] hold_next;
    logic [DATA_WID-1:0] pc_inc;
    logic [DATA_WID-1:0] redirect_tgt;
    logic                req;
    logic                stall;
    logic [DATA_WID-1:0] inst;

    assign pc_inc       = pc + PC_STEP;
    assign redirect_tgt = align_word(redirect_pc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_BOOT;
            pc        <= RESET_PC;
            tgt       <= '0;
            hold_inst <= NOP_INST;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            tgt       <= tgt_next;
            hold_inst <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        tgt_next   = tgt;
        hold_next  = hold_inst;
        req        = 1'b0;
        stall      = 1'b1;
        inst       = NOP_INST;

        case (state)
            ST_BOOT: begin
                state_next = ST_REQ;
            end

            ST_REQ: begin
                req = 1'b1;
                if (imem_ack) begin
                    if (redirect) begin
                        pc_next = redirect_tgt;
                    end else begin
                        stall = 1'b0;
                        inst  = imem_rdata;
                        if (dcache_stall) begin
                            hold_next  = imem_rdata;
                            state_next = ST_HOLD;
                        end else begin
                            pc_next = pc_inc;
                        end
                    end
                end else if (redirect) begin
                    // The bus request cannot be withdrawn, so remember where to go.
                    tgt_next   = redirect_tgt;
                    state_next = ST_DROP;
                end
            end

            ST_HOLD: begin
                stall = 1'b0;
                inst  = hold_inst;
                if (redirect) begin
                    pc_next    = redirect_tgt;
                    hold_next  = NOP_INST;
                    state_next = ST_REQ;
                end else if (!dcache_stall) begin
                    pc_next    = pc_inc;
                    state_next = ST_REQ;
                end
            end

            ST_DROP: begin
                req = 1'b1;
                if (redirect) begin
                    tgt_next = redirect_tgt;
                end
                if (imem_ack) begin
                    pc_next    = redirect ? redirect_tgt : tgt;
                    state_next = ST_REQ;
                end
            end

            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    // BOOT raises icache_stall, but while reset is held the stall must read low.
    assign imem_req     = req;
    assign imem_addr    = pc;
    assign inst_out     = inst;
    assign pc_out       = pc;
    assign icache_stall = stall & rst;

endmodule
